seg_decode: RTL and testbench

SEG_DECODE -- requirements
Module: seg_decode

---
 rtl/seg_decode.sv | 174 +++++++++++++++++
 tb/tb_seg_decode.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decode.sv
// Debounces a scanned, active-low 7-segment display bus and turns it into whole
// frames of BCD digits with per-position decimal-point and validity flags.
module seg_decode #(
  parameter int NDIG   = 8,
  parameter int STABLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  sel_in,
  output logic [31:0] digits_out,
  output logic [7:0]  dp_out,
  output logic [7:0]  valid_mask,
  output logic        frame_done,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam logic [7:0] FULL_MASK = 8'((16'd1 << NDIG) - 16'd1);
  localparam logic [7:0] HOLD_MAX  = 8'(STABLE);

  typedef struct packed {
    logic [3:0] nib;
    logic       valid;
    logic       bad;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] pat);
    dec_t r;
    r.nib   = 4'hE;
    r.valid = 1'b1;
    r.bad   = 1'b0;
    case (pat)
      7'h40:   r.nib = 4'h0;
      7'h79:   r.nib = 4'h1;
      7'h24:   r.nib = 4'h2;
      7'h30:   r.nib = 4'h3;
      7'h19:   r.nib = 4'h4;
      7'h12:   r.nib = 4'h5;
      7'h02:   r.nib = 4'h6;
      7'h78:   r.nib = 4'h7;
      7'h00:   r.nib = 4'h8;
      7'h10:   r.nib = 4'h9;
      7'h7F: begin
        r.nib   = 4'hF;
        r.valid = 1'b0;
      end
      default: begin
        r.nib   = 4'hE;
        r.valid = 1'b0;
        r.bad   = 1'b1;
      end
    endcase
    return r;
  endfunction

  logic [15:0] pair_q, pair_d, prev_q, prev_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] work_dig_q, work_dig_d;
  logic [7:0]  work_dp_q, work_dp_d;
  logic [7:0]  work_val_q, work_val_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  dp_q, dp_d;
  logic [7:0]  valid_q, valid_d;
  logic        frame_done_q, frame_done_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        accept;
  logic        sel_legal;
  logic [7:0]  sel;
  logic [7:0]  seen_nx;
  logic [2:0]  pos;
  dec_t        dec;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    pair_d       = {sel_in, seg_in};
    prev_d       = pair_q;
    seen_d       = seen_q;
    work_dig_d   = work_dig_q;
    work_dp_d    = work_dp_q;
    work_val_d   = work_val_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    if (pair_q == prev_q) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 8'd1;
    end else begin
      hold_d = 8'd0;
    end
    // Accept only on the edge where the hold count first reaches its limit.
    accept = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);

    sel       = pair_q[15:8];
    dec       = decode(pair_q[6:0]);
    sel_legal = $onehot(sel) && ((sel & ~FULL_MASK) == 8'h00);
    seen_nx   = seen_q | sel;
    pos       = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel[i]) pos = 3'(i);
    end

    if (accept && (sel != 8'h00)) begin
      if (!sel_legal) begin
        err_d = 1'b1;
      end else begin
        work_dig_d[{pos, 2'b00} +: 4] = dec.nib;
        work_val_d[pos]               = dec.valid;
        work_dp_d[pos]                = ~pair_q[7];
        err_d                         = dec.bad;
        if (seen_nx == FULL_MASK) begin
          digits_d     = work_dig_d;
          dp_d         = work_dp_d;
          valid_d      = work_val_d;
          frame_done_d = 1'b1;
          seen_d       = 8'h00;
        end else begin
          seen_d = seen_nx;
        end
      end
    end

    err_cnt_d = (err_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop; the working registers are reset
    // too, since a discarded partial frame must not leak into the next one.
    if (rst) begin
      pair_q       <= '0;
      prev_q       <= '0;
      hold_q       <= '0;
      seen_q       <= '0;
      work_dig_q   <= '0;
      work_dp_q    <= '0;
      work_val_q   <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      pair_q       <= pair_d;
      prev_q       <= prev_d;
      hold_q       <= hold_d;
      seen_q       <= seen_d;
      work_dig_q   <= work_dig_d;
      work_dp_q    <= work_dp_d;
      work_val_q   <= work_val_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign digits_out = digits_q;
  assign dp_out     = dp_q;
  assign valid_mask = valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg_decode.sv
// Scoreboard bench for seg_decode: two instances (8 digits/STABLE 1 and
// 4 digits/STABLE 3) share one scanned bus; a behavioural model predicts events.
module tb_seg_decode;

  localparam int NDIG0 = 8, STABLE0 = 1;
  localparam int NDIG1 = 4, STABLE1 = 3;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  val;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [7:0]  sel_in = 8'h00;

  logic [31:0] d0_digits, d1_digits;
  logic [7:0]  d0_dp, d1_dp, d0_valid, d1_valid;
  logic        d0_fd, d1_fd, d0_err, d1_err;
  logic [15:0] d0_cnt, d1_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, advanced when stimulus is driven.
  logic [31:0] m_dig [2];
  logic [7:0]  m_dp [2], m_val [2], m_seen [2];
  logic [15:0] m_cnt [2];
  frame_t      fq0 [$], fq1 [$];
  logic [15:0] eq0 [$], eq1 [$];

  // Published state, advanced when the DUT signals an event.
  frame_t      pub [2];
  logic [15:0] pub_cnt [2];

  logic [6:0] seg_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  seg_decode #(.NDIG(NDIG0), .STABLE(STABLE0)) u_dut0 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in),
    .digits_out(d0_digits), .dp_out(d0_dp), .valid_mask(d0_valid),
    .frame_done(d0_fd), .err(d0_err), .err_cnt(d0_cnt)
  );

  seg_decode #(.NDIG(NDIG1), .STABLE(STABLE1)) u_dut1 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in),
    .digits_out(d1_digits), .dp_out(d1_dp), .valid_mask(d1_valid),
    .frame_done(d1_fd), .err(d1_err), .err_cnt(d1_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_err(input int i);
    if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
    if (i == 0) eq0.push_back(m_cnt[i]);
    else        eq1.push_back(m_cnt[i]);
  endtask

  task automatic model_accept(input int i, input logic [7:0] sel, input logic [7:0] seg);
    int         nd;
    logic [7:0] full;
    int         p;
    logic [3:0] nib;
    logic       ok;
    frame_t     f;
    nd   = (i == 0) ? NDIG0 : NDIG1;
    full = 8'((16'd1 << nd) - 16'd1);
    if (sel == 8'h00) return;
    if (($countones(sel) != 1) || ((sel & ~full) != 8'h00)) begin
      model_err(i);
      return;
    end
    p = 0;
    for (int b = 0; b < 8; b++) if (sel[b]) p = b;
    nib = 4'hE;
    ok  = 1'b0;
    for (int d = 0; d < 10; d++) begin
      if (seg[6:0] == seg_codes[d]) begin
        nib = 4'(d);
        ok  = 1'b1;
      end
    end
    if (seg[6:0] == 7'h7F) nib = 4'hF;
    m_dig[i][p*4 +: 4] = nib;
    m_val[i][p]        = ok;
    m_dp[i][p]         = ~seg[7];
    if (!ok && (seg[6:0] != 7'h7F)) model_err(i);
    m_seen[i][p] = 1'b1;
    if (m_seen[i] == full) begin
      f.dig = m_dig[i];
      f.dp  = m_dp[i];
      f.val = m_val[i];
      if (i == 0) fq0.push_back(f);
      else        fq1.push_back(f);
      m_seen[i] = 8'h00;
    end
  endtask

  // Drive a pair so it is present at n consecutive rising edges.
  task automatic hold(input logic [7:0] sel, input logic [7:0] seg, input int n);
    sel_in = sel;
    seg_in = seg;
    if (n >= STABLE0 + 1) model_accept(0, sel, seg);
    if (n >= STABLE1 + 1) model_accept(1, sel, seg);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [63:0] segs, input int n);
    for (int p = 0; p < 8; p++) begin
      hold(8'(1 << p), segs[p*8 +: 8], n);
      hold(8'h00, 8'hFF, 1);
    end
  endtask

  task automatic pulse_reset();
    check("fq0_pending_at_rst", fq0.size(), 0);
    check("fq1_pending_at_rst", fq1.size(), 0);
    check("eq0_pending_at_rst", eq0.size(), 0);
    check("eq1_pending_at_rst", eq1.size(), 0);
    rst    = 1'b1;
    sel_in = 8'h00;
    seg_in = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      m_dig[i] = '0; m_dp[i] = '0; m_val[i] = '0; m_seen[i] = '0; m_cnt[i] = '0;
      pub[i] = '0; pub_cnt[i] = '0;
    end
    @(negedge clk);
    check("rst_u0_digits", d0_digits, 0);
    check("rst_u0_valid", {24'd0, d0_valid}, 0);
    check("rst_u0_cnt", {16'd0, d0_cnt}, 0);
    check("rst_u1_digits", d1_digits, 0);
    check("rst_u1_pulses", {30'd0, d1_fd, d1_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int i, input logic fd, input logic e, input logic [31:0] dig,
                     input logic [7:0] dp, input logic [7:0] val, input logic [15:0] cnt);
    string pfx;
    pfx = (i == 0) ? "u0" : "u1";
    if (fd) begin
      if ((i == 0 && fq0.size() == 0) || (i == 1 && fq1.size() == 0))
        check({pfx, "_frame_unexpected"}, {31'd0, fd}, 0);
      else if (i == 0) pub[0] = fq0.pop_front();
      else             pub[1] = fq1.pop_front();
    end
    if (e) begin
      if ((i == 0 && eq0.size() == 0) || (i == 1 && eq1.size() == 0))
        check({pfx, "_err_unexpected"}, {31'd0, e}, 0);
      else if (i == 0) pub_cnt[0] = eq0.pop_front();
      else             pub_cnt[1] = eq1.pop_front();
    end
    check({pfx, "_digits"}, dig, pub[i].dig);
    check({pfx, "_dp"}, {24'd0, dp}, {24'd0, pub[i].dp});
    check({pfx, "_valid"}, {24'd0, val}, {24'd0, pub[i].val});
    check({pfx, "_err_cnt"}, {16'd0, cnt}, {16'd0, pub_cnt[i]});
  endtask

  always @(negedge clk) begin
    mon(0, d0_fd, d0_err, d0_digits, d0_dp, d0_valid, d0_cnt);
    mon(1, d1_fd, d1_err, d1_digits, d1_dp, d1_valid, d1_cnt);
  end

  initial begin
    #1;
    pulse_reset();

    // Clean scan, 3 edges per digit: only the STABLE=1 instance accepts.
    scan(64'h80F8_8292_99B0_A4F9, 3);
    hold(8'h00, 8'hFF, 3);
    check("scan1_u0_digits", d0_digits, 32'h8765_4321);
    check("scan1_u0_valid", {24'd0, d0_valid}, 32'hFF);
    check("scan1_u0_dp", {24'd0, d0_dp}, 32'h00);
    check("scan1_u0_cnt", {16'd0, d0_cnt}, 0);
    check("scan1_u1_digits", d1_digits, 0);

    // Illegal pattern, blank with dp, mixed dp; positions 4..7 illegal for u1.
    scan(64'hFF12_90C0_997F_24AA, 5);
    hold(8'h00, 8'hFF, 3);
    check("scan2_u0_digits", d0_digits, 32'hF590_4F2E);
    check("scan2_u0_valid", {24'd0, d0_valid}, 32'h7A);
    check("scan2_u0_dp", {24'd0, d0_dp}, 32'h46);
    check("scan2_u0_cnt", {16'd0, d0_cnt}, 1);
    check("scan2_u1_digits", d1_digits, 32'h0000_4F2E);
    check("scan2_u1_cnt", {16'd0, d1_cnt}, 5);

    // Multi-hot select: 3 edges (below u1 threshold), then 5 edges (one accept each).
    hold(8'h03, 8'hC0, 3);
    hold(8'h00, 8'hFF, 1);
    hold(8'h03, 8'hF9, 5);
    hold(8'h00, 8'hFF, 3);
    check("multihot_u0_cnt", {16'd0, d0_cnt}, 3);
    check("multihot_u1_cnt", {16'd0, d1_cnt}, 6);

    // Partial frame then reset: the five accepted positions must be forgotten.
    for (int p = 0; p < 5; p++) begin
      hold(8'(1 << p), 8'hC0, 2);
      hold(8'h00, 8'hFF, 1);
    end
    pulse_reset();

    // Fresh frame in scrambled order with position 1 overwritten.
    hold(8'h80, 8'h80, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h40, 8'hF8, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h20, 8'h82, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h01, 8'hC0, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h02, 8'hF9, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h02, 8'hB0, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h04, 8'hA4, 2); hold(8'h00, 8'hFF, 1);
    hold(8'h08, 8'h99, 2); hold(8'h00, 8'hFF, 1);
    check("fresh_no_early_frame", d0_digits, 0);

    // Final position: frame must appear exactly two edges after first presentation.
    sel_in = 8'h10;
    seg_in = 8'h92;
    model_accept(0, 8'h10, 8'h92);
    @(posedge clk); @(negedge clk);
    check("latency_edge_k", {31'd0, d0_fd}, 0);
    @(posedge clk); @(negedge clk);
    check("latency_edge_k1", {31'd0, d0_fd}, 0);
    @(posedge clk); @(negedge clk);
    check("latency_edge_k2", {31'd0, d0_fd}, 1);
    sel_in = 8'h00;
    seg_in = 8'hFF;
    @(posedge clk);
    #1;
    hold(8'h00, 8'hFF, 8);
    check("fresh_u0_digits", d0_digits, 32'h8765_4230);
    check("fresh_u0_valid", {24'd0, d0_valid}, 32'hFF);

    check("fq0_left", fq0.size(), 0);
    check("fq1_left", fq1.size(), 0);
    check("eq0_left", eq0.size(), 0);
    check("eq1_left", eq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
